// File: rtl/nonce_dispatch_ctrl.sv
// Multi-core nonce dispatcher: splits [nonce_first, nonce_last] over N_CORES
// hash cores, gathers results, latches the first winning nonce.
module nonce_dispatch_ctrl #(
    parameter int N_CORES = 4,
    parameter int NONCE_W = 32,
    parameter int CNT_W   = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       abort,
    input  logic [NONCE_W-1:0]         nonce_first,
    input  logic [NONCE_W-1:0]         nonce_last,
    output logic [N_CORES-1:0]         core_go,
    output logic [N_CORES*NONCE_W-1:0] core_nonce,
    input  logic [N_CORES-1:0]         core_done,
    input  logic [N_CORES-1:0]         core_hit,
    output logic                       busy,
    output logic                       found,
    output logic [NONCE_W-1:0]         found_nonce,
    output logic                       send_pulse,
    output logic                       exhausted,
    output logic [CNT_W-1:0]           hashes_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FOUND,
        S_EXHAUSTED
    } state_t;

    state_t state, state_n;

    logic [N_CORES-1:0]         core_busy, core_busy_n;
    logic [N_CORES-1:0]         core_go_n;
    logic [N_CORES*NONCE_W-1:0] core_nonce_n;
    logic [NONCE_W-1:0]         next_nonce, next_nonce_n;
    logic [NONCE_W-1:0]         last_nonce, last_nonce_n;
    logic                       range_done, range_done_n;
    logic                       found_n, send_n, exhausted_n;
    logic [NONCE_W-1:0]         found_nonce_n;
    logic [CNT_W-1:0]           hashes_n;

    logic [N_CORES-1:0] acc, hit_vec, hit_pick;
    logic [N_CORES-1:0] free_vec, go_pick;
    logic [CNT_W:0]     cnt_sum;

    always_comb begin
        state_n       = state;
        core_busy_n   = core_busy;
        core_go_n     = '0;
        core_nonce_n  = core_nonce;
        next_nonce_n  = next_nonce;
        last_nonce_n  = last_nonce;
        range_done_n  = range_done;
        found_n       = found;
        found_nonce_n = found_nonce;
        send_n        = 1'b0;
        exhausted_n   = exhausted;
        hashes_n      = hashes_done;

        // Results only count for cores that actually hold an issued nonce
        acc      = core_done & core_busy & {N_CORES{state == S_RUN}};
        hit_vec  = acc & core_hit;
        hit_pick = hit_vec & (~hit_vec + N_CORES'(1));
        free_vec = ~core_busy & {N_CORES{~range_done}};
        go_pick  = free_vec & (~free_vec + N_CORES'(1));

        cnt_sum = {1'b0, hashes_done};
        for (int i = 0; i < N_CORES; i++) begin
            cnt_sum = cnt_sum + (CNT_W+1)'(acc[i]);
        end

        if (start) begin
            next_nonce_n  = nonce_first;
            last_nonce_n  = nonce_last;
            found_n       = 1'b0;
            found_nonce_n = '0;
            exhausted_n   = 1'b0;
            hashes_n      = '0;
            core_busy_n   = '0;
            range_done_n  = 1'b0;
            if (nonce_first > nonce_last) begin
                state_n     = S_EXHAUSTED;
                exhausted_n = 1'b1;
            end else begin
                state_n = S_RUN;
            end
        end else if (state == S_RUN) begin
            if (abort) begin
                state_n     = S_IDLE;
                core_busy_n = '0;
            end else begin
                hashes_n = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
                if (|hit_vec) begin
                    state_n     = S_FOUND;
                    found_n     = 1'b1;
                    send_n      = 1'b1;
                    core_busy_n = '0;
                    for (int i = 0; i < N_CORES; i++) begin
                        if (hit_pick[i]) begin
                            found_nonce_n = core_nonce[i*NONCE_W +: NONCE_W];
                        end
                    end
                end else begin
                    core_busy_n = core_busy & ~acc;
                    if (|go_pick) begin
                        core_go_n   = go_pick;
                        core_busy_n = core_busy_n | go_pick;
                        for (int i = 0; i < N_CORES; i++) begin
                            if (go_pick[i]) begin
                                core_nonce_n[i*NONCE_W +: NONCE_W] = next_nonce;
                            end
                        end
                        // Flag, not compare, so an all-ones last never wraps
                        if (next_nonce == last_nonce) begin
                            range_done_n = 1'b1;
                        end else begin
                            next_nonce_n = next_nonce + NONCE_W'(1);
                        end
                    end else if (range_done && (core_busy == '0)) begin
                        state_n     = S_EXHAUSTED;
                        exhausted_n = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            core_busy   <= '0;
            core_go     <= '0;
            core_nonce  <= '0;
            next_nonce  <= '0;
            last_nonce  <= '0;
            range_done  <= 1'b0;
            busy        <= 1'b0;
            found       <= 1'b0;
            found_nonce <= '0;
            send_pulse  <= 1'b0;
            exhausted   <= 1'b0;
            hashes_done <= '0;
        end else begin
            state       <= state_n;
            core_busy   <= core_busy_n;
            core_go     <= core_go_n;
            core_nonce  <= core_nonce_n;
            next_nonce  <= next_nonce_n;
            last_nonce  <= last_nonce_n;
            range_done  <= range_done_n;
            busy        <= (state_n == S_RUN);
            found       <= found_n;
            found_nonce <= found_nonce_n;
            send_pulse  <= send_n;
            exhausted   <= exhausted_n;
            hashes_done <= hashes_n;
        end
    end

endmodule

// File: tb/tb_nonce_dispatch_ctrl.sv
// Bench for nonce_dispatch_ctrl: cycle model plus emulated hash cores
// with per-core latency and nonce-based hit rules.
module tb_nonce_dispatch_ctrl;

    localparam int N = 4;
    localparam int W = 32;
    localparam int C = 32;
    localparam int P_IDLE = 0;
    localparam int P_RUN = 1;
    localparam int P_FOUND = 2;
    localparam int P_EXH = 3;

    logic         clock = 1'b0;
    logic         reset, start, abort;
    logic [W-1:0] nonce_first, nonce_last;
    logic [N-1:0] core_go, core_done, core_hit;
    logic [N*W-1:0] core_nonce;
    logic         busy, found, send_pulse, exhausted;
    logic [W-1:0] found_nonce;
    logic [C-1:0] hashes_done;

    nonce_dispatch_ctrl #(.N_CORES(N), .NONCE_W(W), .CNT_W(C)) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .nonce_first(nonce_first), .nonce_last(nonce_last),
        .core_go(core_go), .core_nonce(core_nonce),
        .core_done(core_done), .core_hit(core_hit),
        .busy(busy), .found(found), .found_nonce(found_nonce),
        .send_pulse(send_pulse), .exhausted(exhausted),
        .hashes_done(hashes_done)
    );

    always #5 clock = ~clock;

    int nvec = 0;
    int nerr = 0;

    // model state
    int           m_phase;
    bit           m_busy[N];
    logic [W-1:0] m_nonce[N];
    logic [N-1:0] m_go;
    logic [W-1:0] m_next, m_last, m_fn;
    bit           m_rdone, m_found, m_send, m_exh;
    longint       m_hashes;

    // core emulation
    int           cyc;
    int           done_at[N];
    int           lat[N];
    bit           resp_hit[N];
    bit           hit_all, hit_en;
    logic [W-1:0] hit_a, hit_b;

    // observations of the DUT
    int           go_cnt, send_cnt;
    int           go_core_q[$];
    logic [W-1:0] go_nonce_q[$];
    int           go_cyc_q[$];

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic bit is_hit(logic [W-1:0] n);
        return hit_all || (hit_en && (n == hit_a || n == hit_b));
    endfunction

    task automatic model_reset();
        m_phase = P_IDLE;
        for (int i = 0; i < N; i++) begin
            m_busy[i] = 0;
            m_nonce[i] = '0;
        end
        m_go = '0; m_next = '0; m_last = '0; m_fn = '0;
        m_rdone = 0; m_found = 0; m_send = 0; m_exh = 0;
        m_hashes = 0;
    endtask

    task automatic model_step();
        bit prev[N];
        int hitcore = -1;
        int ndone = 0;
        int pick = -1;
        bit anyb = 0;
        m_go = '0;
        m_send = 0;
        if (start) begin
            m_next = nonce_first; m_last = nonce_last;
            m_found = 0; m_fn = '0; m_exh = 0; m_hashes = 0; m_rdone = 0;
            for (int i = 0; i < N; i++) m_busy[i] = 0;
            if (nonce_first > nonce_last) begin
                m_phase = P_EXH;
                m_exh = 1;
            end else begin
                m_phase = P_RUN;
            end
        end else if (m_phase == P_RUN && abort) begin
            m_phase = P_IDLE;
            for (int i = 0; i < N; i++) m_busy[i] = 0;
        end else if (m_phase == P_RUN) begin
            for (int i = 0; i < N; i++) prev[i] = m_busy[i];
            for (int i = 0; i < N; i++) begin
                if (core_done[i] && prev[i]) begin
                    ndone++;
                    m_busy[i] = 0;
                    if (core_hit[i] && hitcore < 0) hitcore = i;
                end
            end
            m_hashes = m_hashes + ndone;
            if (m_hashes > 64'hFFFF_FFFF) m_hashes = 64'hFFFF_FFFF;
            if (hitcore >= 0) begin
                m_phase = P_FOUND;
                m_found = 1;
                m_send = 1;
                m_fn = m_nonce[hitcore];
                for (int i = 0; i < N; i++) m_busy[i] = 0;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (!prev[i] && pick < 0) pick = i;
                    anyb |= prev[i];
                end
                if (!m_rdone && pick >= 0) begin
                    m_go[pick] = 1'b1;
                    m_busy[pick] = 1;
                    m_nonce[pick] = m_next;
                    if (m_next == m_last) m_rdone = 1;
                    else m_next = m_next + 1;
                end else if (m_rdone && !anyb) begin
                    m_phase = P_EXH;
                    m_exh = 1;
                end
            end
        end
    endtask

    task automatic compare();
        logic [N*W-1:0] en;
        for (int i = 0; i < N; i++) en[i*W +: W] = m_nonce[i];
        check("core_go", core_go, m_go);
        check("core_nonce", core_nonce, en);
        check("busy", busy, m_phase == P_RUN);
        check("found", found, m_found);
        check("found_nonce", found_nonce, m_fn);
        check("send_pulse", send_pulse, m_send);
        check("exhausted", exhausted, m_exh);
        check("hashes_done", hashes_done, m_hashes[31:0]);
        go_cnt += $countones(core_go);
        send_cnt += int'(send_pulse);
        for (int i = 0; i < N; i++) begin
            if (core_go[i] === 1'b1) begin
                go_core_q.push_back(i);
                go_nonce_q.push_back(core_nonce[i*W +: W]);
                go_cyc_q.push_back(cyc);
            end
        end
    endtask

    task automatic step();
        core_done = '0;
        core_hit = '0;
        for (int i = 0; i < N; i++) begin
            if (done_at[i] == cyc) begin
                core_done[i] = 1'b1;
                core_hit[i] = resp_hit[i];
            end
        end
        @(posedge clock);
        if (reset) model_reset();
        else model_step();
        #1;
        compare();
        for (int i = 0; i < N; i++) begin
            if (m_go[i]) begin
                done_at[i] = cyc + 1 + lat[i];
                resp_hit[i] = is_hit(m_nonce[i]);
            end
        end
        cyc++;
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic steps(int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic begin_test(logic [W-1:0] f, logic [W-1:0] l);
        for (int i = 0; i < N; i++) done_at[i] = -1;
        go_cnt = 0;
        send_cnt = 0;
        go_core_q.delete();
        go_nonce_q.delete();
        go_cyc_q.delete();
        nonce_first = f;
        nonce_last = l;
        start = 1'b1;
        step();
    endtask

    task automatic run_until_end(int budget);
        int n = 0;
        while (!(found === 1'b1 || exhausted === 1'b1) && n < budget) begin
            step();
            n++;
        end
        check("end_reached", found | exhausted, 1);
    endtask

    task automatic set_lat(int a, int b, int c, int d);
        lat[0] = a; lat[1] = b; lat[2] = c; lat[3] = d;
    endtask

    initial begin
        int saved;
        int idx;
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        nonce_first = '0; nonce_last = '0;
        core_done = '0; core_hit = '0;
        cyc = 0;
        hit_all = 0; hit_en = 0; hit_a = '0; hit_b = '0;
        go_cnt = 0; send_cnt = 0;
        for (int i = 0; i < N; i++) done_at[i] = -1;
        set_lat(10, 10, 10, 10);
        model_reset();
        steps(2);
        check("rst_busy", busy, 0);
        check("rst_go", core_go, 0);
        check("rst_hashes", hashes_done, 0);
        reset = 1'b0;
        steps(2);

        // four nonces over four cores, no hits
        begin_test(32'h100, 32'h103);
        run_until_end(100);
        check("t1_exh", exhausted, 1);
        check("t1_found", found, 0);
        check("t1_hashes", hashes_done, 4);
        check("t1_send", send_cnt, 0);
        check("t1_gocnt", go_cnt, 4);
        for (int k = 0; k < 4 && k < go_core_q.size(); k++) begin
            check("t1_core", go_core_q[k], k);
            check("t1_nonce", go_nonce_q[k], 32'h100 + k);
            check("t1_consec", go_cyc_q[k] - go_cyc_q[0], k);
        end
        steps(3);

        // single hit on 0x2A
        hit_en = 1; hit_a = 32'h2A; hit_b = 32'h2A;
        begin_test(32'h0, 32'hFF);
        run_until_end(400);
        saved = go_cnt;
        steps(5);
        check("t2_found", found, 1);
        check("t2_fn", found_nonce, 32'h2A);
        check("t2_send", send_cnt, 1);
        check("t2_nogo", go_cnt - saved, 0);
        check("t2_busy", busy, 0);
        idx = -1;
        for (int k = 0; k < go_nonce_q.size(); k++)
            if (go_nonce_q[k] == 32'h2A) idx = go_core_q[k];
        check("t2_core", idx, 2);

        // cores 1 and 3 hit on the same edge
        set_lat(20, 12, 20, 10);
        hit_a = 32'h11; hit_b = 32'h13;
        begin_test(32'h10, 32'h13);
        run_until_end(100);
        check("t3_fn", found_nonce, 32'h11);
        check("t3_found", found, 1);
        steps(12);
        check("t3_hashes", hashes_done, 2);
        check("t3_send", send_cnt, 1);

        // top of nonce space, no wrap
        set_lat(10, 10, 10, 10);
        hit_en = 0;
        begin_test(32'hFFFF_FFFE, 32'hFFFF_FFFF);
        run_until_end(100);
        steps(5);
        check("t4_gocnt", go_cnt, 2);
        if (go_nonce_q.size() >= 2) begin
            check("t4_n0", go_nonce_q[0], 32'hFFFF_FFFE);
            check("t4_n1", go_nonce_q[1], 32'hFFFF_FFFF);
        end
        check("t4_exh", exhausted, 1);
        check("t4_hashes", hashes_done, 2);

        // empty range
        begin_test(32'h10, 32'h0F);
        check("t5_exh", exhausted, 1);
        check("t5_go", core_go, 0);
        check("t5_busy", busy, 0);
        steps(3);
        check("t5_gocnt", go_cnt, 0);

        // abort, stale hits, restart, reset in RUN
        hit_all = 1;
        begin_test(32'h0, 32'hFF);
        steps(4);
        abort = 1'b1;
        step();
        check("t6_busy", busy, 0);
        saved = go_cnt;
        steps(15);
        check("t6_found", found, 0);
        check("t6_hashes", hashes_done, 0);
        check("t6_nogo", go_cnt - saved, 0);
        hit_all = 0;
        begin_test(32'h500, 32'h501);
        steps(3);
        check("t6_gocnt", go_cnt, 2);
        if (go_core_q.size() >= 2) begin
            check("t6_c0", go_core_q[0], 0);
            check("t6_n0", go_nonce_q[0], 32'h500);
            check("t6_c1", go_core_q[1], 1);
            check("t6_n1", go_nonce_q[1], 32'h501);
        end
        check("t6_run", busy, 1);
        reset = 1'b1;
        step();
        check("t6_rst_busy", busy, 0);
        check("t6_rst_go", core_go, 0);
        check("t6_rst_nonce", core_nonce, 0);
        check("t6_rst_hashes", hashes_done, 0);
        check("t6_rst_exh", exhausted, 0);
        check("t6_rst_found", found, 0);
        reset = 1'b0;
        steps(2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
